sdhci_buffer_ctrl: RTL and testbench

//  Data-side engine behind the Buffer Data Port. Moves 32-bit words between the SD data line and one block buffer.

---
 rtl/sdhci_pkg.sv | 23 ++
 rtl/sdhci_buffer_ram.sv | 30 +++
 rtl/sdhci_buffer_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sdhci_buffer_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdhci_pkg.sv
// Shared definitions for the SDHCI buffer data path.
//   MaxBlockBytes / BufWords : default block buffer capacity (bytes / 32-bit words)
//   sdhci_buf_state_e        : buffer engine FSM encoding
//   sdhci_writable_reg_t     : {d[15:0], de} hardware update of a software register
package sdhci_pkg;

    localparam int unsigned MaxBlockBytes = 512;
    localparam int unsigned BufWords      = MaxBlockBytes / 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_FILL  = 3'd1,
        ST_RX_DRAIN = 3'd2,
        ST_TX_FILL  = 3'd3,
        ST_TX_SEND  = 3'd4
    } sdhci_buf_state_e;

    typedef struct packed {
        logic [15:0] d;
        logic        de;
    } sdhci_writable_reg_t;

endpackage

// File: rtl/sdhci_buffer_ram.sv
// Single block buffer: Depth x 32 flop array.
//   clk_i   : clock
//   we_i    : write enable (synchronous)
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (combinational read)
//   rdata_o : word at raddr_i
module sdhci_buffer_ram #(
    parameter int unsigned Depth = 128,
    parameter int unsigned AddrW = 7
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sdhci_buffer_ctrl.sv
// Buffer Data Port engine: moves 32-bit words between the SD data line and one
// block buffer, drives the present_state buffer/transfer bits and updates
// Block Count once per completed block.
// Optional feature macro: SDHCI_AUTO_CMD12_EN (Auto CMD12 request pulse).
// Ports:
//   clk_i, rst_ni, rst_dat_ni        : clock, async reset, sync DAT-line reset
//   start_i, stop_i                  : command issued / stop at block gap
//   dir_read_i, multi_block_i, block_count_en_i, auto_cmd12_en_i,
//   block_size_i, block_count_i      : transfer configuration (latched at start)
//   block_count_hw_o                 : {d, de} Block Count update
//   buf_rd_i/buf_rdata_o, buf_wr_i/buf_wdata_i : software Buffer Data Port
//   dat_rx_*                         : words from the SD data receiver
//   dat_tx_*                         : words to the SD data transmitter
//   buffer_*_enable_o, *_xfer_active_o : present_state bits
//   auto_cmd12_req_o                 : Auto CMD12 request pulse
module sdhci_buffer_ctrl
    import sdhci_pkg::*;
#(
    parameter int unsigned MaxBlockBytes = 512
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rst_dat_ni,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        dir_read_i,
    input  logic        multi_block_i,
    input  logic        block_count_en_i,
    input  logic        auto_cmd12_en_i,
    input  logic [11:0] block_size_i,
    input  logic [15:0] block_count_i,
    output logic [16:0] block_count_hw_o,
    input  logic        buf_rd_i,
    output logic [31:0] buf_rdata_o,
    input  logic        buf_wr_i,
    input  logic [31:0] buf_wdata_i,
    input  logic        dat_rx_valid_i,
    input  logic [31:0] dat_rx_data_i,
    output logic        dat_rx_ready_o,
    output logic        dat_tx_valid_o,
    output logic [31:0] dat_tx_data_o,
    input  logic        dat_tx_ready_i,
    output logic        buffer_read_enable_o,
    output logic        buffer_write_enable_o,
    output logic        read_xfer_active_o,
    output logic        write_xfer_active_o,
    output logic        auto_cmd12_req_o
);

    localparam int unsigned NumWords = MaxBlockBytes / 4;
    localparam int unsigned PtrW     = $clog2(NumWords);

    sdhci_buf_state_e    state_q;
    logic [PtrW-1:0]     ptr_q;
    logic [PtrW-1:0]     last_idx_q;
    logic                multi_q;
    logic                count_en_q;
    logic                stop_q;
    logic [15:0]         blocks_left_q;
    sdhci_writable_reg_t bc_hw_q;

    logic [10:0]     wpb_raw;
    logic [PtrW-1:0] last_idx_calc;
    logic            start_ok;
    logic            rx_fire, wr_fire, rd_fire, tx_fire;
    logic            at_last, block_done, counted, last_block, stop_hit, xfer_end;
    logic [31:0]     ram_rdata;

    // Words per block rounded up; a block larger than the buffer is clipped.
    // The pointer range is tracked as the index of the last word so it fits PtrW.
    always_comb begin
        wpb_raw = {1'b0, block_size_i[11:2]} + {10'd0, |block_size_i[1:0]};
        if (wpb_raw >= 11'(NumWords)) begin
            last_idx_calc = PtrW'(NumWords - 1);
        end else begin
            last_idx_calc = wpb_raw[PtrW-1:0] - PtrW'(1);
        end
    end

    assign start_ok = start_i && (state_q == ST_IDLE) && (block_size_i != 12'd0)
                      && !(multi_block_i && block_count_en_i && (block_count_i == 16'd0));

    assign rx_fire    = (state_q == ST_RX_FILL)  && dat_rx_valid_i;
    assign wr_fire    = (state_q == ST_TX_FILL)  && buf_wr_i;
    assign rd_fire    = (state_q == ST_RX_DRAIN) && buf_rd_i;
    assign tx_fire    = (state_q == ST_TX_SEND)  && dat_tx_ready_i;
    assign at_last    = (ptr_q == last_idx_q);
    assign block_done = (rd_fire || tx_fire) && at_last;
    assign counted    = multi_q && count_en_q;
    assign last_block = !multi_q || (counted && (blocks_left_q == 16'd1));
    assign stop_hit   = stop_q || stop_i;
    assign xfer_end   = block_done && (last_block || stop_hit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            last_idx_q    <= '0;
            multi_q       <= 1'b0;
            count_en_q    <= 1'b0;
            stop_q        <= 1'b0;
            blocks_left_q <= '0;
            bc_hw_q       <= '0;
        end else if (!rst_dat_ni) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            last_idx_q    <= '0;
            multi_q       <= 1'b0;
            count_en_q    <= 1'b0;
            stop_q        <= 1'b0;
            blocks_left_q <= '0;
            bc_hw_q       <= '0;
        end else begin
            bc_hw_q.de <= 1'b0;

            if ((state_q != ST_IDLE) && stop_i) begin
                stop_q <= 1'b1;
            end

            if (rx_fire || wr_fire || rd_fire || tx_fire) begin
                ptr_q <= at_last ? '0 : ptr_q + PtrW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q       <= dir_read_i ? ST_RX_FILL : ST_TX_FILL;
                        ptr_q         <= '0;
                        last_idx_q    <= last_idx_calc;
                        multi_q       <= multi_block_i;
                        count_en_q    <= block_count_en_i;
                        blocks_left_q <= block_count_i;
                        stop_q        <= 1'b0;
                    end
                end
                ST_RX_FILL:  if (rx_fire && at_last) state_q <= ST_RX_DRAIN;
                ST_RX_DRAIN: if (block_done) state_q <= xfer_end ? ST_IDLE : ST_RX_FILL;
                ST_TX_FILL:  if (wr_fire && at_last) state_q <= ST_TX_SEND;
                ST_TX_SEND:  if (block_done) state_q <= xfer_end ? ST_IDLE : ST_TX_FILL;
                default:     state_q <= ST_IDLE;
            endcase

            if (block_done && counted) begin
                bc_hw_q.de    <= 1'b1;
                bc_hw_q.d     <= (block_count_i == 16'd0) ? 16'd0 : block_count_i - 16'd1;
                blocks_left_q <= (blocks_left_q == 16'd0) ? 16'd0 : blocks_left_q - 16'd1;
            end

            if (xfer_end) begin
                stop_q <= 1'b0;
            end
        end
    end

`ifdef SDHCI_AUTO_CMD12_EN
    logic cmd12_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd12_q <= 1'b0;
        end else if (!rst_dat_ni) begin
            cmd12_q <= 1'b0;
        end else begin
            cmd12_q <= block_done && counted && auto_cmd12_en_i
                       && (blocks_left_q == 16'd1) && !stop_hit;
        end
    end

    assign auto_cmd12_req_o = cmd12_q;
`else
    logic unused_auto_cmd12_en;
    assign unused_auto_cmd12_en = auto_cmd12_en_i;
    assign auto_cmd12_req_o     = 1'b0;
`endif

    // Fill and drain phases never overlap, so the pointer addresses both ports.
    sdhci_buffer_ram #(
        .Depth (NumWords),
        .AddrW (PtrW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (rx_fire || wr_fire),
        .waddr_i (ptr_q),
        .wdata_i (rx_fire ? dat_rx_data_i : buf_wdata_i),
        .raddr_i (ptr_q),
        .rdata_o (ram_rdata)
    );

    assign block_count_hw_o      = bc_hw_q;
    assign dat_rx_ready_o        = (state_q == ST_RX_FILL);
    assign buffer_read_enable_o  = (state_q == ST_RX_DRAIN);
    assign buffer_write_enable_o = (state_q == ST_TX_FILL);
    assign read_xfer_active_o    = (state_q == ST_RX_FILL) || (state_q == ST_RX_DRAIN);
    assign write_xfer_active_o   = (state_q == ST_TX_FILL) || (state_q == ST_TX_SEND);
    assign dat_tx_valid_o        = (state_q == ST_TX_SEND);
    assign buf_rdata_o           = (state_q == ST_RX_DRAIN) ? ram_rdata : '0;
    assign dat_tx_data_o         = (state_q == ST_TX_SEND)  ? ram_rdata : '0;

endmodule

// File: tb/tb_sdhci_buffer_ctrl.sv
// Directed self-checking bench for sdhci_buffer_ctrl.
module tb_sdhci_buffer_ctrl;

`ifdef SDHCI_AUTO_CMD12_EN
    localparam int ExpCmd12 = 1;
`else
    localparam int ExpCmd12 = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_dat_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dir_read = 1'b0;
    logic        multi = 1'b0;
    logic        cnt_en = 1'b0;
    logic        acmd12_en = 1'b0;
    logic [11:0] bsize = '0;
    logic [16:0] bc_hw;
    logic        buf_rd = 1'b0;
    logic [31:0] buf_rdata;
    logic        buf_wr = 1'b0;
    logic [31:0] buf_wdata = '0;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_ready;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready = 1'b0;
    logic        rd_en, wr_en, rd_act, wr_act, cmd12;

    // Block Count register model, written back by the DUT's {d, de} update
    logic [15:0] bc_reg = '0;
    logic [15:0] bc_init = '0;
    logic        bc_load = 1'b0;
    logic [15:0] de_log[$];
    int          cmd12_cnt = 0;
    int          cmd12_d0 = 0;

    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdhci_buffer_ctrl #(.MaxBlockBytes(512)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .rst_dat_ni            (rst_dat_n),
        .start_i               (start),
        .stop_i                (stop),
        .dir_read_i            (dir_read),
        .multi_block_i         (multi),
        .block_count_en_i      (cnt_en),
        .auto_cmd12_en_i       (acmd12_en),
        .block_size_i          (bsize),
        .block_count_i         (bc_reg),
        .block_count_hw_o      (bc_hw),
        .buf_rd_i              (buf_rd),
        .buf_rdata_o           (buf_rdata),
        .buf_wr_i              (buf_wr),
        .buf_wdata_i           (buf_wdata),
        .dat_rx_valid_i        (rx_valid),
        .dat_rx_data_i         (rx_data),
        .dat_rx_ready_o        (rx_ready),
        .dat_tx_valid_o        (tx_valid),
        .dat_tx_data_o         (tx_data),
        .dat_tx_ready_i        (tx_ready),
        .buffer_read_enable_o  (rd_en),
        .buffer_write_enable_o (wr_en),
        .read_xfer_active_o    (rd_act),
        .write_xfer_active_o   (wr_act),
        .auto_cmd12_req_o      (cmd12)
    );

    always @(posedge clk) begin
        if (bc_load) bc_reg <= bc_init;
        else if (bc_hw[0]) bc_reg <= bc_hw[16:1];
        if (bc_hw[0]) de_log.push_back(bc_hw[16:1]);
        if (cmd12) begin
            cmd12_cnt <= cmd12_cnt + 1;
            if (bc_hw[0] && bc_hw[16:1] == 16'd0) cmd12_d0 <= cmd12_d0 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_count(input logic [15:0] v);
        bc_init = v;
        bc_load = 1'b1;
        @(negedge clk);
        bc_load = 1'b0;
    endtask

    task automatic start_xfer(input logic rd, input logic mb, input logic ce, input logic [11:0] sz);
        dir_read = rd; multi = mb; cnt_en = ce; bsize = sz;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_rx(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = base + 32'(i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic drain(input int n, input logic [31:0] base, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, buf_rdata, base + 32'(i));
            buf_rd = 1'b1;
            @(negedge clk);
        end
        buf_rd = 1'b0;
    endtask

    initial begin
        int log_base;
        int c12_base;
        int d0_base;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_flags", {27'd0, rd_en, wr_en, rd_act, wr_act, rx_ready}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_bc_hw", {15'd0, bc_hw}, 32'd0);
        chk("rst_cmd12", {31'd0, cmd12}, 32'd0);
        chk("rst_rdata", buf_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single 512-byte read
        log_base = de_log.size();
        start_xfer(1'b1, 1'b0, 1'b0, 12'd512);
        chk("t1_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("t1_rd_act", {31'd0, rd_act}, 32'd1);
        fill_rx(127, 32'hA500_0000);
        chk("t1_rden_before_last", {31'd0, rd_en}, 32'd0);
        rx_valid = 1'b1; rx_data = 32'hA500_007F;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("t1_rden_rise", {31'd0, rd_en}, 32'd1);
        chk("t1_rx_ready_off", {31'd0, rx_ready}, 32'd0);
        drain(128, 32'hA500_0000, "t1_rdata");
        chk("t1_rden_drop", {31'd0, rd_en}, 32'd0);
        chk("t1_rd_act_drop", {31'd0, rd_act}, 32'd0);
        chk("t1_no_count_write", 32'(de_log.size() - log_base), 32'd0);

        // 2: write, 8 bytes, 3 counted blocks
        set_count(16'd3);
        log_base = de_log.size();
        c12_base = cmd12_cnt;
        start_xfer(1'b0, 1'b1, 1'b1, 12'd8);
        chk("t2_wr_act", {31'd0, wr_act}, 32'd1);
        for (int b = 0; b < 3; b++) begin
            chk("t2_wren", {31'd0, wr_en}, 32'd1);
            buf_wr = 1'b1; buf_wdata = 32'h5500_0000 + 32'(b * 16);
            @(negedge clk);
            buf_wdata = 32'h5500_0001 + 32'(b * 16);
            @(negedge clk);
            buf_wr = 1'b0;
            chk("t2_wren_drop", {31'd0, wr_en}, 32'd0);
            chk("t2_tx_valid", {31'd0, tx_valid}, 32'd1);
            chk("t2_tx_w0", tx_data, 32'h5500_0000 + 32'(b * 16));
            tx_ready = 1'b1;
            @(negedge clk);
            chk("t2_tx_w1", tx_data, 32'h5500_0001 + 32'(b * 16));
            chk("t2_wr_act_hold", {31'd0, wr_act}, 32'd1);
            @(negedge clk);
            tx_ready = 1'b0;
        end
        chk("t2_wr_act_fall", {31'd0, wr_act}, 32'd0);
        chk("t2_tx_valid_off", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t2_count_writes", 32'(de_log.size() - log_base), 32'd3);
        if (de_log.size() - log_base == 3) begin
            chk("t2_d_blk0", {16'd0, de_log[log_base]}, 32'd2);
            chk("t2_d_blk1", {16'd0, de_log[log_base + 1]}, 32'd1);
            chk("t2_d_blk2", {16'd0, de_log[log_base + 2]}, 32'd0);
        end
        chk("t2_bc_reg", {16'd0, bc_reg}, 32'd0);
        chk("t2_no_cmd12", 32'(cmd12_cnt - c12_base), 32'd0);

        // 3: read 6 bytes, count 2, stop during block 1
        set_count(16'd2);
        acmd12_en = 1'b1;
        log_base = de_log.size();
        c12_base = cmd12_cnt;
        start_xfer(1'b1, 1'b1, 1'b1, 12'd6);
        stop = 1'b1; rx_valid = 1'b1; rx_data = 32'h3300_0000;
        @(negedge clk);
        stop = 1'b0; rx_data = 32'h3300_0001;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("t3_rden", {31'd0, rd_en}, 32'd1);
        drain(2, 32'h3300_0000, "t3_rdata");
        chk("t3_rd_act_end", {31'd0, rd_act}, 32'd0);
        chk("t3_no_refill", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t3_count_writes", 32'(de_log.size() - log_base), 32'd1);
        if (de_log.size() - log_base == 1) chk("t3_d", {16'd0, de_log[log_base]}, 32'd1);
        chk("t3_no_cmd12", 32'(cmd12_cnt - c12_base), 32'd0);

        // 4: Auto CMD12 on last counted block
        set_count(16'd2);
        log_base = de_log.size();
        c12_base = cmd12_cnt;
        d0_base  = cmd12_d0;
        start_xfer(1'b1, 1'b1, 1'b1, 12'd4);
        fill_rx(1, 32'h4400_0000);
        drain(1, 32'h4400_0000, "t4_rdata0");
        chk("t4_refill", {31'd0, rx_ready}, 32'd1);
        fill_rx(1, 32'h4400_0010);
        drain(1, 32'h4400_0010, "t4_rdata1");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t4_count_writes", 32'(de_log.size() - log_base), 32'd2);
        chk("t4_cmd12_pulses", 32'(cmd12_cnt - c12_base), 32'(ExpCmd12));
        chk("t4_cmd12_with_d0", 32'(cmd12_d0 - d0_base), 32'(ExpCmd12));
        acmd12_en = 1'b0;

        // 5: DAT reset mid drain
        start_xfer(1'b1, 1'b0, 1'b0, 12'd8);
        fill_rx(2, 32'h5A00_0000);
        drain(1, 32'h5A00_0000, "t5_rdata0");
        rst_dat_n = 1'b0; buf_rd = 1'b1;
        @(negedge clk);
        rst_dat_n = 1'b1;
        chk("t5_flags_clr", {27'd0, rd_en, wr_en, rd_act, wr_act, rx_ready}, 32'd0);
        chk("t5_rdata_clr", buf_rdata, 32'd0);
        @(negedge clk);
        buf_rd = 1'b0;
        chk("t5_rd_ignored", {31'd0, rd_en}, 32'd0);
        start_xfer(1'b1, 1'b0, 1'b0, 12'd8);
        fill_rx(2, 32'h5B00_0000);
        drain(2, 32'h5B00_0000, "t5_restart_rdata");
        chk("t5_restart_done", {31'd0, rd_act}, 32'd0);

        // 6: guards
        start_xfer(1'b1, 1'b0, 1'b0, 12'd0);
        chk("t6_size0", {30'd0, rd_act, rx_ready}, 32'd0);
        set_count(16'd0);
        start_xfer(1'b1, 1'b1, 1'b1, 12'd8);
        chk("t6_count0", {30'd0, rd_act, rx_ready}, 32'd0);
        start_xfer(1'b1, 1'b0, 1'b0, 12'd8);
        fill_rx(2, 32'h6600_0000);
        start_xfer(1'b0, 1'b0, 1'b0, 12'd8);
        chk("t6_busy_start", {30'd0, rd_en, wr_en}, 32'd2);
        buf_wr = 1'b1; buf_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        buf_wr = 1'b0;
        drain(2, 32'h6600_0000, "t6_mem_kept");
        chk("t6_done", {30'd0, rd_act, wr_act}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
